// File: rtl/load_store_unit.sv
// Data-memory access stage: one ready-handshaked bus transaction per command,
// lane steering for byte/half/word stores and extension of load results.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_sign,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t     state;
  logic [1:0] size_q;
  logic       sign_q;
  logic [1:0] off_q;
  logic       we_q;

  // Decode of the incoming command, consumed only when start is accepted.
  logic        is_half;
  logic        is_word;
  logic        cmd_misaligned;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;

  always_comb begin
    is_half        = (mem_size == 2'b01);
    is_word        = mem_size[1];
    cmd_misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    cmd_be         = 4'b0001 << addr[1:0];
    cmd_wdata      = {4{wdata[7:0]}};
    if (is_word) begin
      cmd_be    = 4'b1111;
      cmd_wdata = wdata;
    end else if (is_half) begin
      cmd_be    = 4'b0011 << {addr[1], 1'b0};
      cmd_wdata = {2{wdata[15:0]}};
    end
  end

  // Load extraction works from the latched command so late input changes are harmless.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (size_q[1])
      ld_value = bus_rdata;
    else if (size_q == 2'b01)
      ld_value = {{16{sign_q & ld_half[15]}}, ld_half};
    else
      ld_value = {{24{sign_q & ld_byte[7]}}, ld_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      off_q      <= 2'b00;
      we_q       <= 1'b0;
      mem_rdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= 4'b0000;
      bus_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          if (start) begin
            size_q <= mem_size;
            sign_q <= mem_sign;
            off_q  <= addr[1:0];
            we_q   <= mem_we;
            busy   <= 1'b1;
            if (cmd_misaligned) begin
              state      <= ERR;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= cmd_be;
              bus_wdata <= cmd_wdata;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            done    <= 1'b1;
            if (!we_q)
              mem_rdata <= ld_value;
          end
        end
        DONE, ERR: begin
          state      <= IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// commands against an arithmetic reference model, and multi-cycle corner cases.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_we(mem_we), .mem_size(mem_size),
    .mem_sign(mem_sign), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .misaligned(misaligned), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        sign;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        waits;
    bit        exp_mis;
    bit [3:0]  exp_be;
    bit [31:0] exp_bwdata;
    bit [31:0] exp_rd;
  } vec_t;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] ref_rdata = 32'h0;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: access width in bytes, lane offset, and plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t            r;
    int unsigned     n;
    int unsigned     off;
    longint unsigned val;
    longint unsigned lim;
    r   = v;
    n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = v.addr % 4;
    r.exp_mis = (v.addr % n) != 0;
    r.exp_be  = 4'(((1 << n) - 1) << off);
    if (n == 1)      r.exp_bwdata = (v.wdata & 32'hFF) * 32'h0101_0101;
    else if (n == 2) r.exp_bwdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
    else             r.exp_bwdata = v.wdata;
    lim = 64'd1 << (8 * n);
    val = v.rdata;
    val = (val >> (8 * off)) % lim;
    if (v.sign && n < 4 && val >= lim / 2)
      val = val + 64'h1_0000_0000 - lim;
    r.exp_rd = val[31:0];
    return r;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    int          cyc;
    int          req_cyc;
    bit          seen;
    logic [31:0] exp_rd;
    exp_rd    = (!v.we && !v.exp_mis) ? v.exp_rd : ref_rdata;
    start     = 1'b1;
    mem_we    = v.we;
    mem_size  = v.size;
    mem_sign  = v.sign;
    addr      = v.addr;
    wdata     = v.wdata;
    bus_ready = 1'($urandom % 2);
    cyc = 0; req_cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      start     = 1'b0;
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      addr      = $urandom;
      wdata     = $urandom;
      mem_size  = 2'($urandom % 4);
      mem_sign  = 1'($urandom % 2);
      mem_we    = 1'($urandom % 2);
      cyc++;
      if (cyc == 1) chk({tag, " busy"}, busy, 1);
      if (bus_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          chk({tag, " bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
          chk({tag, " bus_be"}, bus_be, v.exp_be);
          chk({tag, " bus_we"}, bus_we, v.we);
          if (v.we) chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
        end
        if (req_cyc == v.waits + 1) begin
          bus_ready = 1'b1;
          bus_rdata = v.rdata;
        end
      end
      if (done) begin
        seen = 1;
        chk({tag, " misaligned"}, misaligned, v.exp_mis);
        chk({tag, " latency"}, cyc, v.exp_mis ? 1 : v.waits + 2);
        chk({tag, " req_cycles"}, req_cyc, v.exp_mis ? 0 : v.waits + 1);
        chk({tag, " mem_rdata"}, mem_rdata, exp_rd);
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    bus_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {busy, done, bus_req}, 3'b000);
    ref_rdata = exp_rd;
  endtask

  initial begin
    int   reqs;
    int   dones;
    int   done_at;
    logic prev_req;
    vec_t v;

    // we, size, sign, addr, wdata, rdata, waits, exp_mis, exp_be, exp_bwdata, exp_rd
    tbl[0]  = '{0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{0, 2'b01, 0, 32'h2002, 32'h0, 32'h9ABC_1234, 3, 0, 4'b1100, 32'h0, 32'h0000_9ABC};
    tbl[2]  = '{1, 2'b00, 0, 32'h11, 32'h1234_56A5, 32'h0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[3]  = '{1, 2'b10, 0, 32'h14, 32'hDEAD_BEEF, 32'h0, 1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[4]  = '{0, 2'b10, 0, 32'h6, 32'h0, 32'h1111_1111, 0, 1, 4'b0000, 32'h0, 32'h0};
    tbl[5]  = '{1, 2'b01, 0, 32'h3, 32'hCAFE_0000, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0};
    tbl[6]  = '{0, 2'b00, 1, 32'h2001, 32'h0, 32'h1122_8344, 2, 0, 4'b0010, 32'h0, 32'hFFFF_FF83};
    tbl[7]  = '{0, 2'b01, 1, 32'h3000, 32'h0, 32'h0000_F00D, 0, 0, 4'b0011, 32'h0, 32'hFFFF_F00D};
    tbl[8]  = '{0, 2'b11, 1, 32'h40, 32'h0, 32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0, 32'hCAFE_F00D};
    tbl[9]  = '{1, 2'b01, 0, 32'h22, 32'hAAAA_5A5B, 32'h0, 0, 0, 4'b1100, 32'h5A5B_5A5B, 32'h0};
    tbl[10] = '{0, 2'b01, 1, 32'h5, 32'h0, 32'hFFFF_FFFF, 0, 1, 4'b0000, 32'h0, 32'h0};
    tbl[11] = '{0, 2'b00, 0, 32'h7, 32'h0, 32'h7F00_0000, 0, 0, 4'b1000, 32'h0, 32'h0000_007F};

    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_rdata", mem_rdata, 32'h0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset misaligned", misaligned, 0);
    chk("reset bus_req", bus_req, 0);
    chk("reset bus_we", bus_we, 0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_be", bus_be, 4'b0000);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 150; i++) begin
      v.we    = 1'($urandom % 2);
      v.size  = 2'($urandom % 4);
      v.sign  = 1'($urandom % 2);
      v.addr  = $urandom;
      if ($urandom % 4 != 0)
        v.addr = v.addr & ((v.size == 2'b00) ? 32'hFFFF_FFFF : (v.size == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.waits = $urandom % 4;
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    // A second start during REQ and during DONE must not create another command.
    start = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_sign = 1'b0; addr = 32'h100;
    prev_req = 1'b0; reqs = 0; dones = 0; done_at = -1;
    for (int i = 1, n = 0; i <= 10; i++) begin
      @(posedge clk); #1;
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      if (bus_req && !prev_req) reqs++;
      prev_req = bus_req;
      if (bus_req) begin
        n++;
        if (n == 2) begin
          bus_ready = 1'b1;
          bus_rdata = 32'h5555_55C3;
        end
      end
      if (done) begin
        dones++;
        done_at = i;
      end
      if (i == 1) begin
        addr     = 32'h203;
        mem_size = 2'b10;
      end
      start = (done_at < 0) || (done_at == i);
    end
    start = 1'b0;
    chk("busy_start req_count", reqs, 1);
    chk("busy_start done_count", dones, 1);
    chk("busy_start done_cycle", done_at, 3);
    chk("busy_start mem_rdata", mem_rdata, 32'h0000_00C3);
    ref_rdata = 32'h0000_00C3;

    // Reset while a request is outstanding abandons it and clears the load result.
    start = 1'b1; mem_we = 1'b0; mem_size = 2'b10; addr = 32'h80; bus_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrst req_before", bus_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst bus_req", bus_req, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst mem_rdata", mem_rdata, 32'h0);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("midrst no_done", {done, bus_req}, 2'b00);
    ref_rdata = 32'h0;
    v = '{0, 2'b10, 0, 32'h84, 32'h0, 32'h0BAD_CAFE, 1, 0, 4'b1111, 32'h0, 32'h0BAD_CAFE};
    run_txn("after_rst", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
